// File: rtl/ofm_writeback.sv
// rtl/ofm_writeback.sv - OFM write-back: tiles of PE results to masked multi-element RAM write beats
module ofm_writeback #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int INOUT_WIDTH   = 128,
    parameter int OFM_SIZE      = 26,
    parameter int NO_FILTER     = 256,
    parameter int ADDR_WIDTH    = 18
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [SYSTOLIC_SIZE*2*DATA_WIDTH-1:0] in_data,
    output logic                                  wr_en,
    output logic [ADDR_WIDTH-1:0]                 wr_addr,
    output logic [INOUT_WIDTH-1:0]                wr_data,
    output logic [INOUT_WIDTH/(2*DATA_WIDTH)-1:0] wr_mask,
    output logic                                  done
);
    localparam int EW        = 2 * DATA_WIDTH;
    localparam int WR_LANES  = INOUT_WIDTH / EW;
    localparam int TW        = SYSTOLIC_SIZE * EW;
    localparam int NTPL      = (OFM_SIZE + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
    localparam int MAX_BEATS = (SYSTOLIC_SIZE + WR_LANES - 1) / WR_LANES;
    localparam int TX_W      = (NTPL > 1) ? $clog2(NTPL) : 1;
    localparam int Y_W       = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;
    localparam int F_W       = (NO_FILTER > 1) ? $clog2(NO_FILTER) : 1;
    localparam int B_W       = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int N_W       = $clog2(SYSTOLIC_SIZE + 1);

    typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} state_t;

    state_t                  state, state_nxt;
    logic [TX_W-1:0]         tx_q, tx_nxt;
    logic [Y_W-1:0]          y_q, y_nxt;
    logic [F_W-1:0]          f_q, f_nxt;
    logic [B_W-1:0]          beat_q, beat_nxt;
    logic [TW-1:0]           tile_q, tile_nxt;
    logic [N_W-1:0]          n_q, n_nxt;
    logic                    rdy_nxt, wen_nxt, done_nxt;
    logic [ADDR_WIDTH-1:0]   addr_nxt, base;
    logic [INOUT_WIDTH-1:0]  data_nxt;
    logic [WR_LANES-1:0]     mask_nxt;
    int                      x0, n_cur, nb, b_next;
    logic                    last_tx, last_y, last_f;

    // Lanes past the valid element count are forced to zero, not left stale.
    function automatic logic [INOUT_WIDTH-1:0] beat_data(input logic [TW-1:0] tile, input int n, input int b);
        beat_data = '0;
        for (int k = 0; k < WR_LANES; k++) begin
            if (b * WR_LANES + k < n)
                beat_data[k*EW +: EW] = tile[(b*WR_LANES+k)*EW +: EW];
        end
    endfunction

    function automatic logic [WR_LANES-1:0] beat_mask(input int n, input int b);
        beat_mask = '0;
        for (int k = 0; k < WR_LANES; k++)
            beat_mask[k] = (b * WR_LANES + k < n);
    endfunction

    always_comb begin
        x0      = int'(tx_q) * SYSTOLIC_SIZE;
        n_cur   = (OFM_SIZE - x0 < SYSTOLIC_SIZE) ? (OFM_SIZE - x0) : SYSTOLIC_SIZE;
        nb      = (int'(n_q) + WR_LANES - 1) / WR_LANES;
        b_next  = int'(beat_q) + 1;
        base    = ADDR_WIDTH'(f_q) * ADDR_WIDTH'(OFM_SIZE * OFM_SIZE)
                + ADDR_WIDTH'(y_q) * ADDR_WIDTH'(OFM_SIZE)
                + ADDR_WIDTH'(x0);
        last_tx = (tx_q == TX_W'(NTPL - 1));
        last_y  = (y_q == Y_W'(OFM_SIZE - 1));
        last_f  = (f_q == F_W'(NO_FILTER - 1));
    end

    always_comb begin
        state_nxt = state;
        tx_nxt    = tx_q;
        y_nxt     = y_q;
        f_nxt     = f_q;
        beat_nxt  = beat_q;
        tile_nxt  = tile_q;
        n_nxt     = n_q;
        rdy_nxt   = 1'b0;
        wen_nxt   = 1'b0;
        addr_nxt  = '0;
        data_nxt  = '0;
        mask_nxt  = '0;
        done_nxt  = 1'b0;
        if (start) begin
            state_nxt = WAIT;
            tx_nxt    = '0;
            y_nxt     = '0;
            f_nxt     = '0;
            beat_nxt  = '0;
            rdy_nxt   = 1'b1;
        end else begin
            case (state)
                IDLE: ;
                WAIT: begin
                    // Beat 0 goes out straight from in_data so the first write follows the handshake edge.
                    if (in_valid && in_ready) begin
                        state_nxt = WRITE;
                        tile_nxt  = in_data;
                        n_nxt     = N_W'(n_cur);
                        beat_nxt  = '0;
                        wen_nxt   = 1'b1;
                        addr_nxt  = base;
                        data_nxt  = beat_data(in_data, n_cur, 0);
                        mask_nxt  = beat_mask(n_cur, 0);
                    end else begin
                        rdy_nxt = 1'b1;
                    end
                end
                WRITE: begin
                    if (b_next < nb) begin
                        beat_nxt = beat_q + B_W'(1);
                        wen_nxt  = 1'b1;
                        addr_nxt = base + ADDR_WIDTH'(b_next * WR_LANES);
                        data_nxt = beat_data(tile_q, int'(n_q), b_next);
                        mask_nxt = beat_mask(int'(n_q), b_next);
                    end else if (last_tx && last_y && last_f) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        rdy_nxt   = 1'b1;
                        if (!last_tx) begin
                            tx_nxt = tx_q + TX_W'(1);
                        end else begin
                            tx_nxt = '0;
                            if (!last_y) begin
                                y_nxt = y_q + Y_W'(1);
                            end else begin
                                y_nxt = '0;
                                f_nxt = f_q + F_W'(1);
                            end
                        end
                    end
                end
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_q     <= '0;
            y_q      <= '0;
            f_q      <= '0;
            beat_q   <= '0;
            tile_q   <= '0;
            n_q      <= '0;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_mask  <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx_q     <= tx_nxt;
            y_q      <= y_nxt;
            f_q      <= f_nxt;
            beat_q   <= beat_nxt;
            tile_q   <= tile_nxt;
            n_q      <= n_nxt;
            in_ready <= rdy_nxt;
            wr_en    <= wen_nxt;
            wr_addr  <= addr_nxt;
            wr_data  <= data_nxt;
            wr_mask  <= mask_nxt;
            done     <= done_nxt;
        end
    end
endmodule

// File: tb/tb_ofm_writeback.sv
// tb/tb_ofm_writeback.sv - self-checking bench for ofm_writeback
module tb_ofm_writeback;
    localparam int SS     = 16;
    localparam int OS     = 26;
    localparam int NF     = 256;
    localparam int WL     = 8;
    localparam int NTPL   = 2;
    localparam int NTILES = NTPL * OS * NF;
    localparam int NADDR  = OS * OS * NF;

    logic         clk = 0, rst_n = 0, start = 0, in_valid = 0;
    logic [255:0] in_data = '0;
    logic         in_ready, wr_en, done;
    logic [17:0]  wr_addr;
    logic [127:0] wr_data;
    logic [7:0]   wr_mask;

    ofm_writeback dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_mask(wr_mask), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0]  a;
        logic [7:0]   m;
        logic [127:0] d;
        bit           fin;
    } beat_t;

    int    n_cmp = 0, n_fail = 0;
    int    acc = 0, tcnt = 0;
    bit    armed = 0, done_exp = 0, cov_on = 0;
    beat_t q[$];
    bit    cov [NADDR];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [255:0] mk(input int v, input int cnt);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            if (i < cnt) r[16*i +: 16] = 16'(v + i);
        return r;
    endfunction

    // Expected beats for the next tile, derived from its position in raster order.
    task automatic push_tile(input logic [255:0] d);
        int tx, y, f, x0, n, nb, base;
        beat_t e;
        tx = tcnt % NTPL;
        y  = (tcnt / NTPL) % OS;
        f  = tcnt / (NTPL * OS);
        x0 = tx * SS;
        n  = (OS - x0 < SS) ? OS - x0 : SS;
        nb = (n + WL - 1) / WL;
        base = f * OS * OS + y * OS + x0;
        for (int b = 0; b < nb; b++) begin
            e.a = 18'(base + b * WL);
            e.m = '0;
            e.d = '0;
            for (int k = 0; k < WL; k++)
                if (b * WL + k < n) begin
                    e.m[k] = 1'b1;
                    e.d[16*k +: 16] = d[16*(b*WL+k) +: 16];
                end
            e.fin = (tcnt == NTILES - 1) && (b == nb - 1);
            q.push_back(e);
        end
        tcnt++;
    endtask

    always @(negedge clk) begin
        bit    rd, fin;
        beat_t e;
        fin = 0;
        if (!rst_n) begin
            q.delete();
            armed = 0;
            tcnt = 0;
            done_exp = 0;
        end
        rd = armed && (q.size() == 0);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("beat", {wr_en, wr_addr, wr_mask, wr_data}, {1'b1, e.a, e.m, e.d});
            fin = e.fin;
            if (fin) armed = 0;
        end else begin
            chk("idle_out", {wr_en, wr_addr, wr_mask, wr_data}, '0);
        end
        if (cov_on && wr_en)
            for (int k = 0; k < WL; k++)
                if (wr_mask[k] && int'(wr_addr) + k < NADDR) begin
                    chk("cov_dup", cov[int'(wr_addr)+k], 0);
                    cov[int'(wr_addr)+k] = 1;
                end
        chk("done", done, done_exp);
        done_exp = fin;
        chk("in_ready", in_ready, rd);
        if (rst_n) begin
            if (start) begin
                q.delete();
                armed = 1;
                tcnt = 0;
                done_exp = 0;
            end else if (rd && in_valid) begin
                push_tile(in_data);
                acc++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic send(input logic [255:0] d, input bit hold);
        int a0, w;
        a0 = acc;
        w = 0;
        in_data = d;
        in_valid = 1;
        while (acc == a0 && w < 200) begin
            tick();
            w++;
        end
        if (acc == a0) chk("accept_timeout", 0, 1);
        if (!hold) in_valid = 0;
    endtask

    task automatic lit(input logic [17:0] a, input logic [7:0] m, input logic [255:0] d);
        @(negedge clk);
        chk("lit_beat", {wr_en, wr_addr, wr_mask, wr_data}, {1'b1, a, m, d[127:0]});
        chk("lit_ready_low", in_ready, 0);
    endtask

    initial begin
        int cnt;
        repeat (3) tick();
        rst_n = 1;
        tick();
        @(negedge clk);
        chk("reset_state", {in_ready, wr_en, done, wr_addr, wr_mask, wr_data}, '0);
        tick();
        pulse_start();

        send(mk(1, 16), 0);
        lit(0, 8'hFF, mk(1, 8));
        lit(8, 8'hFF, mk(9, 8));
        @(negedge clk);
        chk("ready_after_tile", in_ready, 1);
        tick();

        send(mk(17, 16), 0);
        lit(16, 8'hFF, mk(17, 8));
        lit(24, 8'h03, mk(25, 2));
        tick();

        for (int t = 2; t < 52; t++) send(mk(100 + t, 16), 0);
        send(mk(1000, 16), 0);
        lit(676, 8'hFF, mk(1000, 8));
        tick();

        send(mk(3000, 16), 0);
        lit(692, 8'hFF, mk(3000, 8));
        tick();
        pulse_start();
        send(mk(1, 16), 0);
        lit(0, 8'hFF, mk(1, 8));
        tick();

        send(mk(500, 16), 0);
        pulse_start();
        repeat (4) tick();
        send(mk(7, 16), 0);
        lit(0, 8'hFF, mk(7, 8));
        tick();

        rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
        in_data = mk(50, 16);
        in_valid = 1;
        repeat (8) begin
            @(negedge clk);
            chk("idle_no_capture", {in_ready, wr_en}, 0);
        end
        tick();
        pulse_start();
        @(negedge clk);
        chk("capture_cycle", {in_ready, wr_en}, 2'b10);
        lit(0, 8'hFF, mk(50, 8));
        tick();
        in_valid = 0;
        repeat (3) tick();

        for (int i = 0; i < NADDR; i++) cov[i] = 0;
        cov_on = 1;
        pulse_start();
        for (int t = 0; t < NTILES; t++) begin
            if (t == NTILES - 1)
                send(mk(2000, 16), 0);
            else
                send({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1);
        end
        lit(173046, 8'hFF, mk(2000, 8));
        lit(173054, 8'h03, mk(2008, 2));
        @(negedge clk);
        chk("done_pulse", done, 1);
        repeat (20) begin
            @(negedge clk);
            chk("after_done_quiet", {in_ready, done, wr_en}, 0);
        end
        cov_on = 0;
        cnt = 0;
        for (int i = 0; i < NADDR; i++) cnt += int'(cov[i]);
        chk("cov_all", 256'(cnt), 256'(NADDR));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
